// File: rtl/code_entry_controller.sv
// Keypad lock sequencer: buffers four key symbols, replays them into a CodeDetector,
// then applies the unlock window, failure counting, inter-key timeout and lockout.
module code_entry_controller #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start_Btn,
  input  logic       Key_Valid,
  input  logic [2:0] Key_In,
  input  logic       Det_U,
  output logic       Det_S,
  output logic [2:0] Det_In,
  output logic       Det_Reset,
  output logic       Unlock,
  output logic       Fail,
  output logic       Timeout,
  output logic       Locked_Out,
  output logic       Busy,
  output logic [2:0] Fail_Cnt
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] COLLECT = 4'd1;
  localparam logic [3:0] CLEAR   = 4'd2;
  localparam logic [3:0] ARM     = 4'd3;
  localparam logic [3:0] FEED0   = 4'd4;
  localparam logic [3:0] FEED1   = 4'd5;
  localparam logic [3:0] FEED2   = 4'd6;
  localparam logic [3:0] FEED3   = 4'd7;
  localparam logic [3:0] CHECK   = 4'd8;
  localparam logic [3:0] UNLOCK  = 4'd9;
  localparam logic [3:0] LOCKOUT = 4'd10;

  localparam int MAXP = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ?
                        ((TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES) :
                        ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES);
  localparam int TW = $clog2(MAXP + 1);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] UL_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LO_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    TRIES   = 3'(MAX_TRIES);

  logic [3:0]      state;
  logic [1:0]      cnt;
  logic [TW-1:0]   timer;
  logic [3:0][2:0] key_buf;
  logic [2:0]      fail_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      timer    <= '0;
      key_buf  <= '0;
      fail_cnt <= '0;
      Fail     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      Fail    <= 1'b0;
      Timeout <= 1'b0;
      case (state)
        IDLE: if (Start_Btn) begin
          state <= COLLECT;
          cnt   <= '0;
          timer <= '0;
        end
        COLLECT: begin
          // A restart takes priority over a key arriving in the same cycle
          if (Start_Btn) begin
            cnt   <= '0;
            timer <= '0;
          end else if (Key_Valid) begin
            key_buf[cnt] <= Key_In;
            timer        <= '0;
            cnt          <= cnt + 2'd1;
            if (cnt == 2'd3) state <= CLEAR;
          end else if (timer == TO_LAST) begin
            state   <= IDLE;
            timer   <= '0;
            cnt     <= '0;
            Timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CLEAR: state <= ARM;
        ARM:   state <= FEED0;
        FEED0: state <= FEED1;
        FEED1: state <= FEED2;
        FEED2: state <= FEED3;
        FEED3: state <= CHECK;
        CHECK: begin
          timer <= '0;
          if (Det_U) begin
            fail_cnt <= '0;
            state    <= UNLOCK;
          end else begin
            Fail     <= 1'b1;
            fail_cnt <= fail_cnt + 3'd1;
            state    <= (fail_cnt + 3'd1 == TRIES) ? LOCKOUT : IDLE;
          end
        end
        UNLOCK: begin
          if (timer == UL_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer == LO_LAST) begin
            state    <= IDLE;
            timer    <= '0;
            fail_cnt <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Det_In = 3'd0;
    case (state)
      FEED0:   Det_In = key_buf[0];
      FEED1:   Det_In = key_buf[1];
      FEED2:   Det_In = key_buf[2];
      FEED3:   Det_In = key_buf[3];
      default: Det_In = 3'd0;
    endcase
  end

  assign Det_Reset  = Reset | (state == CLEAR);
  assign Det_S      = (state == ARM);
  assign Unlock     = (state == UNLOCK);
  assign Locked_Out = (state == LOCKOUT);
  assign Busy       = (state != IDLE);
  assign Fail_Cnt   = fail_cnt;

endmodule

// File: tb/tb_code_entry_controller.sv
// Bench for code_entry_controller: behavioural CodeDetector, attempt-level outcome model,
// directed scenarios followed by randomized attempts.
module tb_code_entry_controller;

  localparam int MAX_TRIES = 3;
  localparam int TO_CYC    = 1000;
  localparam int UL_CYC    = 50;
  localparam int LO_CYC    = 500;

  logic       Clk = 1'b0;
  logic       Reset, Start_Btn, Key_Valid, Det_U;
  logic [2:0] Key_In;
  logic       Det_S, Det_Reset, Unlock, Fail, Timeout, Locked_Out, Busy;
  logic [2:0] Det_In, Fail_Cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_fail = 0;
  int arm_cnt = 0;

  logic [3:0][2:0] code_v;
  logic [3:0][2:0] keys;

  always #5 Clk = ~Clk;

  code_entry_controller #(
    .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYCLES(TO_CYC),
    .UNLOCK_CYCLES(UL_CYC), .LOCKOUT_CYCLES(LO_CYC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start_Btn(Start_Btn), .Key_Valid(Key_Valid),
    .Key_In(Key_In), .Det_U(Det_U), .Det_S(Det_S), .Det_In(Det_In),
    .Det_Reset(Det_Reset), .Unlock(Unlock), .Fail(Fail), .Timeout(Timeout),
    .Locked_Out(Locked_Out), .Busy(Busy), .Fail_Cnt(Fail_Cnt)
  );

  // Behavioural CodeDetector: after S, captures the next four symbols; U is Moore
  logic [2:0] dbuf [4];
  int         dn;
  logic       darm;
  always @(posedge Clk) begin
    if (Det_Reset) begin
      darm <= 1'b0;
      dn   <= 0;
    end else if (Det_S) begin
      darm <= 1'b1;
      dn   <= 0;
    end else if (darm && dn < 4) begin
      dbuf[dn] <= Det_In;
      dn       <= dn + 1;
    end
    if (Det_S) arm_cnt <= arm_cnt + 1;
  end
  assign Det_U = (dn == 4) && dbuf[0] == 3'd1 && dbuf[1] == 3'd2 &&
                 dbuf[2] == 3'd4 && dbuf[3] == 3'd1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_det_reset"}, Det_Reset, 1);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_unlock"}, Unlock, 0);
    chk({tag, "_locked"}, Locked_Out, 0);
    chk({tag, "_fail"}, Fail, 0);
    chk({tag, "_timeout"}, Timeout, 0);
    chk({tag, "_det_s"}, Det_S, 0);
    chk({tag, "_det_in"}, Det_In, 0);
    chk({tag, "_fail_cnt"}, Fail_Cnt, 0);
  endtask

  task automatic start_entry();
    Start_Btn = 1'b1;
    step();
    Start_Btn = 1'b0;
    chk("start_busy", Busy, 1);
  endtask

  task automatic send_key(input logic [2:0] k, input int gap);
    repeat (gap) step();
    Key_Valid = 1'b1;
    Key_In    = k;
    step();
    Key_Valid = 1'b0;
    Key_In    = 3'd0;
  endtask

  // Called at the first negedge after the 4th key edge; checks replay and outcome
  task automatic finish(input logic [3:0][2:0] k);
    int n;
    bit match;
    match = (k == code_v);
    chk("clear_det_reset", Det_Reset, 1);
    step();
    chk("arm_det_s", Det_S, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("feed_det_in", Det_In, k[i]);
      chk("feed_det_s", Det_S, 0);
    end
    step();
    chk("check_busy", Busy, 1);
    step();
    if (match) begin
      exp_fail = 0;
      chk("match_unlock", Unlock, 1);
      chk("match_fail", Fail, 0);
      chk("match_fail_cnt", Fail_Cnt, 0);
      n = 0;
      while (Unlock && n < UL_CYC + 20) begin
        n++;
        step();
      end
      chk("unlock_len", n, UL_CYC);
      chk("unlock_idle", Busy, 0);
    end else begin
      exp_fail++;
      chk("miss_fail", Fail, 1);
      chk("miss_unlock", Unlock, 0);
      chk("miss_fail_cnt", Fail_Cnt, exp_fail);
      if (exp_fail == MAX_TRIES) begin
        chk("lockout_on", Locked_Out, 1);
        n = 0;
        while (Locked_Out && n < LO_CYC + 20) begin
          n++;
          Start_Btn = (n == 100);
          step();
        end
        Start_Btn = 1'b0;
        chk("lockout_len", n, LO_CYC);
        chk("lockout_idle", Busy, 0);
        chk("lockout_fail_cnt", Fail_Cnt, 0);
        exp_fail = 0;
      end else begin
        chk("miss_idle", Busy, 0);
        step();
        chk("fail_pulse_end", Fail, 0);
      end
    end
  endtask

  task automatic attempt(input logic [3:0][2:0] k, input int gap);
    start_entry();
    for (int i = 0; i < 4; i++) send_key(k[i], gap);
    finish(k);
  endtask

  initial begin
    int n;
    int arm0;
    logic [3:0][2:0] bad;
    code_v    = {3'd1, 3'd4, 3'd2, 3'd1};
    bad       = {3'd2, 3'd4, 3'd2, 3'd1};
    Reset     = 1'b1;
    Start_Btn = 1'b0;
    Key_Valid = 1'b0;
    Key_In    = 3'd0;
    step();
    step();
    chk_rst("por");
    Reset = 1'b0;
    step();
    chk("idle_det_reset", Det_Reset, 0);

    // Keys in IDLE are ignored
    send_key(3'd1, 0);
    chk("idle_key_ignored", Busy, 0);

    attempt(code_v, 3);
    for (int t = 0; t < MAX_TRIES; t++) attempt(bad, 1);

    // One failure, then a timeout that leaves the counter alone, then a good code clears it
    attempt(bad, 0);
    start_entry();
    send_key(3'd1, 0);
    send_key(3'd2, 2);
    arm0 = arm_cnt;
    n = 0;
    do begin
      step();
      n++;
    end while (!Timeout && n < TO_CYC + 100);
    chk("timeout_cycles", n, TO_CYC);
    chk("timeout_idle", Busy, 0);
    chk("timeout_fail_cnt", Fail_Cnt, exp_fail);
    chk("timeout_no_arm", arm_cnt, arm0);
    step();
    chk("timeout_pulse_end", Timeout, 0);
    attempt(code_v, 2);

    // Start and Key_Valid together: the key is dropped and entry restarts
    start_entry();
    send_key(3'd1, 1);
    Start_Btn = 1'b1;
    send_key(3'd1, 0);
    Start_Btn = 1'b0;
    chk("restart_busy", Busy, 1);
    for (int i = 0; i < 4; i++) send_key(code_v[i], 1);
    finish(code_v);

    // Reset during FEED2
    start_entry();
    for (int i = 0; i < 4; i++) send_key(code_v[i], 0);
    repeat (4) step();
    chk("feed2_det_in", Det_In, code_v[2]);
    Reset = 1'b1;
    step();
    chk_rst("rst_feed2");
    Reset = 1'b0;
    step();
    exp_fail = 0;

    // Reset during UNLOCK, with a nonzero failure count beforehand
    attempt(bad, 0);
    start_entry();
    for (int i = 0; i < 4; i++) send_key(code_v[i], 0);
    repeat (7) step();
    chk("pre_rst_unlock", Unlock, 1);
    repeat (10) step();
    Reset = 1'b1;
    step();
    chk_rst("rst_unlock");
    Reset = 1'b0;
    step();
    exp_fail = 0;

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1) keys = code_v;
      else for (int i = 0; i < 4; i++) keys[i] = 3'($urandom_range(0, 7));
      attempt(keys, int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
